// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the multicycle controller: state codes, datapath select
// encodings, instruction-class enum and the opcode/funct values it decodes.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP = 3'd0,
        CLS_ALU = 3'd1,
        CLS_LW  = 3'd2,
        CLS_SW  = 3'd3,
        CLS_BEQ = 3'd4,
        CLS_JR  = 3'd5,
        CLS_JAL = 3'd6
    } cls_t;

    localparam logic [1:0] RD_RT = 2'd0;
    localparam logic [1:0] RD_RD = 2'd1;
    localparam logic [1:0] RD_RA = 2'd2;

    localparam logic [1:0] RS_ALU = 2'd0;
    localparam logic [1:0] RS_MEM = 2'd1;
    localparam logic [1:0] RS_PC4 = 2'd2;

    localparam logic [2:0] NPC_PC4    = 3'd0;
    localparam logic [2:0] NPC_BRANCH = 3'd1;
    localparam logic [2:0] NPC_JUMP   = 3'd2;
    localparam logic [2:0] NPC_JR     = 3'd3;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;
    localparam logic [2:0] ALU_LUI = 3'd3;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_JAL   = 6'h03;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_LUI   = 6'h0F;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;

endpackage

// File: rtl/main_decoder.sv
// Combinational op decode: maps opcode/funct to the single-cycle select values
// and the instruction class that steers the multicycle FSM.
module main_decoder
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output cls_t       cls,
    output logic [1:0] reg_dst,
    output logic       alu_src,
    output logic [1:0] reg_src,
    output logic       ext_op,
    output logic [2:0] alu_ctrl
);

    always_comb begin
        cls      = CLS_NOP;
        reg_dst  = RD_RT;
        alu_src  = 1'b0;
        reg_src  = RS_ALU;
        ext_op   = 1'b0;
        alu_ctrl = ALU_ADD;
        case (opcode)
            OPC_RTYPE: begin
                case (funct)
                    FN_ADD: begin cls = CLS_ALU; reg_dst = RD_RD; end
                    FN_SUB: begin cls = CLS_ALU; reg_dst = RD_RD; alu_ctrl = ALU_SUB; end
                    FN_JR:  cls = CLS_JR;
                    default: cls = CLS_NOP;
                endcase
            end
            OPC_ORI: begin cls = CLS_ALU; alu_src = 1'b1; alu_ctrl = ALU_OR; end
            OPC_LUI: begin cls = CLS_ALU; alu_src = 1'b1; alu_ctrl = ALU_LUI; end
            OPC_LW: begin
                cls     = CLS_LW;
                alu_src = 1'b1;
                reg_src = RS_MEM;
                ext_op  = 1'b1;
            end
            OPC_SW:  begin cls = CLS_SW; alu_src = 1'b1; ext_op = 1'b1; end
            OPC_BEQ: begin cls = CLS_BEQ; ext_op = 1'b1; alu_ctrl = ALU_SUB; end
            OPC_JAL: begin cls = CLS_JAL; reg_dst = RD_RA; reg_src = RS_PC4; end
            default: cls = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control unit: FETCH/DECODE/EXEC/MEM/WB sequencing,
// write strobes, memory handshake and a retired-instruction counter.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int RET_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ack,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             mem_req,
    output logic [1:0]       RegDst,
    output logic             ALUSrc,
    output logic [1:0]       RegSrc,
    output logic [2:0]       nPC_Sel,
    output logic             ExtOp,
    output logic [2:0]       ALUCtrl,
    output logic [2:0]       state,
    output logic [RET_W-1:0] instr_retired
);

    state_t           state_q, state_d;
    logic [RET_W-1:0] ret_q;

    cls_t       dec_cls;
    logic [1:0] dec_reg_dst;
    logic       dec_alu_src;
    logic [1:0] dec_reg_src;
    logic       dec_ext_op;
    logic [2:0] dec_alu_ctrl;

    main_decoder u_dec (
        .opcode   (opcode),
        .funct    (funct),
        .cls      (dec_cls),
        .reg_dst  (dec_reg_dst),
        .alu_src  (dec_alu_src),
        .reg_src  (dec_reg_src),
        .ext_op   (dec_ext_op),
        .alu_ctrl (dec_alu_ctrl)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            if (PCWrite) begin
                ret_q <= ret_q + RET_W'(1);
            end
        end
    end

    // Outputs are Mealy on zero/mem_ack and forced to defaults while reset is
    // high, so an abort inside MEM removes MemWrite within the same cycle.
    always_comb begin
        state_d  = state_q;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        RegWrite = 1'b0;
        MemWrite = 1'b0;
        mem_req  = 1'b0;
        RegDst   = RD_RT;
        ALUSrc   = 1'b0;
        RegSrc   = RS_ALU;
        nPC_Sel  = NPC_PC4;
        ExtOp    = 1'b0;
        ALUCtrl  = ALU_ADD;
        if (!reset) begin
            if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
                RegDst  = dec_reg_dst;
                ALUSrc  = dec_alu_src;
                RegSrc  = dec_reg_src;
                ExtOp   = dec_ext_op;
                ALUCtrl = dec_alu_ctrl;
            end
            case (state_q)
                S_FETCH: begin
                    IRWrite = 1'b1;
                    state_d = S_DECODE;
                end
                S_DECODE: begin
                    case (dec_cls)
                        CLS_JAL: state_d = S_WB;
                        CLS_NOP: begin PCWrite = 1'b1; state_d = S_FETCH; end
                        default: state_d = S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    case (dec_cls)
                        CLS_ALU:        state_d = S_WB;
                        CLS_LW, CLS_SW: state_d = S_MEM;
                        CLS_BEQ: begin
                            PCWrite = 1'b1;
                            nPC_Sel = zero ? NPC_BRANCH : NPC_PC4;
                            state_d = S_FETCH;
                        end
                        CLS_JR: begin
                            PCWrite = 1'b1;
                            nPC_Sel = NPC_JR;
                            state_d = S_FETCH;
                        end
                        default: state_d = S_FETCH;
                    endcase
                end
                S_MEM: begin
                    mem_req  = 1'b1;
                    MemWrite = (dec_cls == CLS_SW);
                    if (mem_ack) begin
                        if (dec_cls == CLS_LW) begin
                            state_d = S_WB;
                        end else begin
                            PCWrite = 1'b1;
                            state_d = S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    RegWrite = 1'b1;
                    PCWrite  = 1'b1;
                    nPC_Sel  = (dec_cls == CLS_JAL) ? NPC_JUMP : NPC_PC4;
                    state_d  = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    assign state         = state_q;
    assign instr_retired = ret_q;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: RET_W, default 32, width of the retired-instruction counter.
REQ-002 Port: clk, input, 1, the only clock; all state updates on its rising edge.
REQ-003 Port: reset, input, 1, asynchronous, active-high.
REQ-004 Port: opcode, input, 6, instr[31:26] from the IR; stable from DECODE until the instruction retires.
REQ-005 Port: funct, input, 6, instr[5:0] from the IR.
REQ-006 Port: zero, input, 1, ALU zero flag; sampled in EXEC.
REQ-007 Port: mem_ack, input, 1, data-memory completion for the current mem_req.
REQ-008 Ports: IRWrite, PCWrite, RegWrite, MemWrite and mem_req, output, 1 each, write strobes and the memory request.
REQ-009 Ports: RegDst (2), ALUSrc (1), RegSrc (2), nPC_Sel (3), ExtOp (1) and ALUCtrl (3), output, datapath selects with the existing encodings.
REQ-010 Port: state, output, 3, current FSM state; instr_retired, output, RET_W, count of retired instructions.

Function
REQ-011 Supported ops: add, sub, jr (opcode 0 with funct 0x20, 0x22, 0x08), ori, lw, sw, beq, lui and jal; any other encoding is a NOP.
REQ-012 States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 go to FETCH on the next edge, and all outputs are 0 while in them.
REQ-013 FETCH: IRWrite=1 for exactly one cycle, then go to DECODE.
REQ-014 DECODE transitions: jal goes to WB; NOP goes to FETCH with PCWrite=1 and nPC_Sel=PC4; every other supported op goes to EXEC.
REQ-015 EXEC for add, sub, ori and lui: go to WB.
REQ-016 EXEC for lw and sw: go to MEM.
REQ-017 EXEC for beq: PCWrite=1, nPC_Sel=BRANCH if zero=1 else PC4, then go to FETCH.
REQ-018 EXEC for jr: PCWrite=1, nPC_Sel=JR, then go to FETCH.
REQ-019 MEM: mem_req=1, plus MemWrite=1 for sw; hold MEM until mem_ack=1. On the ack cycle, lw goes to WB; sw asserts PCWrite=1 with nPC_Sel=PC4 and goes to FETCH.
REQ-020 WB: RegWrite=1, PCWrite=1 and nPC_Sel=PC4 (nPC_Sel=JUMP for jal), then go to FETCH.
REQ-021 Select values in EXEC, MEM and WB follow the single-cycle decode for the op; RegWrite and MemWrite are never asserted outside WB and MEM respectively.
REQ-022 Latency in cycles: NOP 2; beq, jr and jal 3; add, sub, ori, lui and sw (zero-wait) 4; lw (zero-wait) 5; each extra cycle with mem_ack=0 adds 1.
REQ-023 PCWrite is asserted exactly once per instruction.
REQ-024 instr_retired increments on every cycle with PCWrite=1 and wraps modulo 2^RET_W.
REQ-025 mem_ack outside MEM is ignored.
REQ-026 A mem_ack held high across consecutive instructions completes each MEM in one cycle.

Reset
REQ-027 While reset=1: state=FETCH, instr_retired=0, and every strobe and mem_req is 0.
REQ-028 While reset=1, all selects take their defaults: RD_RT, ALUSrc 0, RS_ALU, NPC_PC4, ExtOp 0, ALU_ADD.
REQ-029 Reset asserted mid-instruction, including inside a MEM wait, aborts it immediately with no write strobe.
REQ-030 After reset, the first rising edge with reset=0 executes FETCH.

Structure
REQ-031 State codes, RD_*, RS_*, NPC_*, ALU_* and the opcode/funct values live in the shared constants package.
REQ-032 Sub-module main_decoder: pure combinational op-class decode (opcode, funct) to the select values and instruction class; the FSM consumes that class.

Verification
REQ-033 ori $1,$0,0x5 -> states 0,1,2,4; RegWrite=1 only in cycle 4 with ALUCtrl=OR and ALUSrc=1; instr_retired 0->1.
REQ-034 lw with mem_ack low 2 cycles -> MEM held 3 cycles with mem_req=1 and MemWrite=0, then WB with RegSrc=MEM; total 7 cycles.
REQ-035 beq with zero=1, then beq with zero=0 -> EXEC nPC_Sel=BRANCH then PC4, PCWrite=1 in each, 3 cycles each.
REQ-036 jal then jr -> jal: DECODE to WB with RegDst=RA, RegSrc=PC4, nPC_Sel=JUMP; jr: EXEC nPC_Sel=JR, RegWrite never 1.
REQ-037 opcode 0x3F -> FETCH, DECODE, FETCH; PCWrite=1 in DECODE; no RegWrite or MemWrite.
REQ-038 sw with reset pulsed during MEM wait -> MemWrite drops the same cycle, state=0, instr_retired=0, no PCWrite.
